// File: rtl/clk_div_chain_pkg.sv
// Shared timing constants for the master-clock divider chain.
// Consumers of the divided clocks import the stage count from here.
package clk_div_chain_pkg;

    localparam int unsigned DIV_STAGES = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } divState_e;

endpackage

// File: rtl/clk_div_strobe.sv
// Rise/fall enable decode for a binary divider counter.
// Shared by every divider that feeds the negedge register stages.
module clk_div_strobe #(
    parameter int unsigned STAGES = 4
) (
    input  logic [STAGES-1:0] cnt,
    input  logic              adv,
    output logic [STAGES-1:0] riseCe,
    output logic [STAGES-1:0] fallCe,
    output logic              wrap
);

    // ones[k] is set when every bit below k is one
    logic [STAGES:0] ones;

    assign ones[0] = 1'b1;

    for (genvar k = 0; k < STAGES; k++) begin : g_bit
        assign ones[k+1]  = ones[k] & cnt[k];
        assign riseCe[k]  = adv & ~cnt[k] & ones[k];
        assign fallCe[k]  = adv & ones[k+1];
    end

    assign wrap = fallCe[STAGES-1];

endmodule

// File: rtl/clk_div_chain.sv
// Synchronous divide-by-2^k chain with freeze and phase resync.
// DIV levels come straight from the counter; strobes lead each edge.
module clk_div_chain
    import clk_div_chain_pkg::*;
#(
    parameter int unsigned       STAGES     = DIV_STAGES,
    parameter logic [STAGES-1:0] SYNC_VALUE = '0
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              EN,
    input  logic              SYNC,
    output logic [STAGES-1:0] DIV,
    output logic [STAGES-1:0] RISE_CE,
    output logic [STAGES-1:0] FALL_CE,
    output logic              WRAP,
    output logic              RUNNING
);

    divState_e         state;
    logic [STAGES-1:0] cnt;
    logic [STAGES-1:0] cntNext;
    logic              syncQ;
    logic              pend;
    logic              load;
    logic              adv;

    assign load    = syncQ | pend;
    assign cntNext = cnt + STAGES'(1);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= RUN;
            cnt   <= '0;
            syncQ <= 1'b0;
            pend  <= 1'b0;
        end else begin
            syncQ <= SYNC;
            unique case (state)
                RUN: begin
                    if (load) begin
                        cnt  <= SYNC_VALUE;
                        pend <= 1'b0;
                    end else begin
                        cnt  <= cntNext;
                    end
                    if (!EN) state <= HOLD;
                end
                HOLD: begin
                    if (syncQ) pend <= 1'b1;
                    if (EN) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // No edge can advance the counter while reset is held,
    // so strobes stay quiet for the whole reset interval.
    assign adv = (state == RUN) & ~load & nRESET;

    clk_div_strobe #(
        .STAGES (STAGES)
    ) u_strobe (
        .cnt    (cnt),
        .adv    (adv),
        .riseCe (RISE_CE),
        .fallCe (FALL_CE),
        .wrap   (WRAP)
    );

    assign DIV     = cnt;
    assign RUNNING = (state == RUN);

endmodule

// File: tb/tb_clk_div_chain.sv
// Vector and scoreboard bench for clk_div_chain (STAGES=4, SYNC_VALUE=3).
module tb_clk_div_chain;

    localparam int          N  = 4;
    localparam logic [N-1:0] SV = 4'd3;

    logic         CLK = 1'b0;
    logic         nRESET;
    logic         EN;
    logic         SYNC;
    logic [N-1:0] DIV;
    logic [N-1:0] RISE_CE;
    logic [N-1:0] FALL_CE;
    logic         WRAP;
    logic         RUNNING;

    always #5 CLK = ~CLK;

    clk_div_chain #(
        .STAGES     (N),
        .SYNC_VALUE (SV)
    ) dut (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .EN      (EN),
        .SYNC    (SYNC),
        .DIV     (DIV),
        .RISE_CE (RISE_CE),
        .FALL_CE (FALL_CE),
        .WRAP    (WRAP),
        .RUNNING (RUNNING)
    );

    typedef struct {
        logic         en;
        logic         sync;
        logic [N-1:0] div;
        logic         run;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];
    vec_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the chain; mRun=1 means running
    logic [N-1:0] mCnt;
    logic         mRun;
    logic         mSyncQ;
    logic         mPend;

    always @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            mCnt   <= '0;
            mRun   <= 1'b1;
            mSyncQ <= 1'b0;
            mPend  <= 1'b0;
        end else begin
            mSyncQ <= SYNC;
            if (mRun) begin
                if (mSyncQ || mPend) begin
                    mCnt  <= SV;
                    mPend <= 1'b0;
                end else begin
                    mCnt  <= mCnt + N'(1);
                end
                if (!EN) mRun <= 1'b0;
            end else begin
                if (mSyncQ) mPend <= 1'b1;
                if (EN) mRun <= 1'b1;
            end
        end
    end

    logic         prevAdv  = 1'b0;
    logic [N-1:0] prevDiv  = '0;
    logic [N-1:0] prevRise = '0;
    logic [N-1:0] prevFall = '0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic checkModel(input string tag);
        logic         adv;
        logic [N-1:0] nxt;
        logic [N-1:0] r;
        logic [N-1:0] f;
        adv = nRESET && mRun && !mSyncQ && !mPend;
        nxt = mCnt + N'(1);
        for (int k = 0; k < N; k++) begin
            r[k] = adv & ~mCnt[k] & nxt[k];
            f[k] = adv & mCnt[k] & ~nxt[k];
        end
        chk({tag, "_rise"}, 32'(RISE_CE), 32'(r));
        chk({tag, "_fall"}, 32'(FALL_CE), 32'(f));
        chk({tag, "_wrap"}, 32'(WRAP), 32'(adv && (mCnt == '1)));
        if (prevAdv) begin
            chk({tag, "_riseEdge"}, 32'(~prevDiv & DIV), 32'(prevRise));
            chk({tag, "_fallEdge"}, 32'(prevDiv & ~DIV), 32'(prevFall));
        end
        prevAdv  = adv;
        prevDiv  = DIV;
        prevRise = RISE_CE;
        prevFall = FALL_CE;
    endtask

    function automatic vec_t mk(input bit en, input bit sync,
                                input int div, input bit run);
        vec_t v;
        v.en   = en;
        v.sync = sync;
        v.div  = div[N-1:0];
        v.run  = run;
        return v;
    endfunction

    // Called at a negedge: drive, let one edge pass, compare, return at negedge
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        EN   = v.en;
        SYNC = v.sync;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({tag, "_div"}, 32'(DIV), 32'(e.div));
        chk({tag, "_run"}, 32'(RUNNING), 32'(e.run));
        checkModel(tag);
        @(negedge CLK);
    endtask

    initial begin
        // Free run through a wrap, then freeze at 5->6
        for (int i = 1; i <= 21; i++) t1.push_back(mk(1, 0, i % 16, 1));
        t1.push_back(mk(0, 0, 6, 0));
        t1.push_back(mk(0, 0, 6, 0));
        t1.push_back(mk(1, 0, 6, 1));
        t1.push_back(mk(1, 0, 7, 1));
        t1.push_back(mk(1, 0, 8, 1));
        t1.push_back(mk(1, 0, 9, 1));
        // Resync while running at 9
        t1.push_back(mk(1, 1, 10, 1));
        t1.push_back(mk(1, 0, 3, 1));
        t1.push_back(mk(1, 0, 4, 1));
        for (int i = 5; i <= 11; i++) t1.push_back(mk(1, 0, i, 1));
        // Resync during hold at 12
        t1.push_back(mk(0, 0, 12, 0));
        t1.push_back(mk(0, 1, 12, 0));
        t1.push_back(mk(0, 0, 12, 0));
        t1.push_back(mk(1, 0, 12, 1));
        t1.push_back(mk(1, 0, 3, 1));
        t1.push_back(mk(1, 0, 4, 1));
        for (int i = 5; i <= 10; i++) t1.push_back(mk(1, 0, i, 1));
        // Hold at 11 with a resync left pending
        t1.push_back(mk(0, 0, 11, 0));
        t1.push_back(mk(0, 1, 11, 0));
        t1.push_back(mk(0, 0, 11, 0));

        // After reset: pending resync gone, then SYNC held high
        t2.push_back(mk(1, 0, 1, 1));
        t2.push_back(mk(1, 0, 2, 1));
        t2.push_back(mk(1, 1, 3, 1));
        t2.push_back(mk(1, 1, 3, 1));
        t2.push_back(mk(1, 1, 3, 1));
        t2.push_back(mk(1, 0, 3, 1));
        t2.push_back(mk(1, 0, 4, 1));
        t2.push_back(mk(1, 0, 5, 1));

        nRESET = 1'b0;
        EN     = 1'b1;
        SYNC   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_div",  32'(DIV),     32'd0);
        chk("rst_run",  32'(RUNNING), 32'd1);
        chk("rst_rise", 32'(RISE_CE), 32'd0);
        chk("rst_fall", 32'(FALL_CE), 32'd0);
        chk("rst_wrap", 32'(WRAP),    32'd0);

        @(negedge CLK);
        nRESET = 1'b1;
        foreach (t1[i]) step(t1[i], $sformatf("t1_%0d", i + 1));

        // Asynchronous reset mid-cycle while held with pend=1
        #2;
        nRESET = 1'b0;
        #1;
        chk("arst_div",  32'(DIV),     32'd0);
        chk("arst_run",  32'(RUNNING), 32'd1);
        chk("arst_rise", 32'(RISE_CE), 32'd0);
        chk("arst_fall", 32'(FALL_CE), 32'd0);
        prevAdv = 1'b0;

        @(negedge CLK);
        nRESET = 1'b1;
        foreach (t2[i]) step(t2[i], $sformatf("t2_%0d", i + 1));

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
